// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RV32I five-stage stall/flush/forwarding controller with data-memory wait timeout.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_reg_write,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        load_use;
  logic        timeout_hit;
  logic        stall_all;
  logic        resolve;
  logic [1:0]  fwd_a_raw, fwd_b_raw;

  assign load_use = ex_load && ex_reg_write && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt_q == WAIT_TIMEOUT - 1);

  // The youngest producer (EX/MEM) wins; x0 is hardwired zero and never forwarded.
  assign fwd_a_raw = (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) ? 2'b01 :
                     (wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs1)) ? 2'b10 : 2'b00;
  assign fwd_b_raw = (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) ? 2'b01 :
                     (wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs2)) ? 2'b10 : 2'b00;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_all   = 1'b0;
    resolve     = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    mem_timeout = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;

    if (state_q == ST_RUN) begin
      if (mem_req && !dmem_ready) begin
        stall_all  = 1'b1;
        state_d    = ST_WAIT;
        wait_cnt_d = 32'd0;
      end else begin
        resolve = 1'b1;
      end
    end else begin
      wait_cnt_d = wait_cnt_q + 32'd1;
      if (dmem_ready) begin
        resolve = 1'b1;
        state_d = ST_RUN;
      end else if (timeout_hit) begin
        mem_timeout = 1'b1;
        state_d     = ST_RUN;
      end else begin
        stall_all = 1'b1;
      end
    end

    // A redirect discards the dependent instruction, so it outranks load-use.
    if (resolve) begin
      if (ex_redirect) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end

    if (stall_all) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end

    if (!rst) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      stall_mem   = 1'b0;
      flush_id    = 1'b1;
      flush_ex    = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
      mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_if && (perf_stall_q != {CNT_W{1'b1}})) perf_stall_q <= perf_stall_q + CNT_W'(1);
      if (flush_id && (perf_flush_q != {CNT_W{1'b1}})) perf_flush_q <= perf_flush_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
